// File: rtl/cronometro_pkg.sv
// Stopwatch definitions shared by the control, counter and display blocks:
// state encoding, decoded button commands and the command priority rule.
package cronometro_pkg;

    typedef enum logic [1:0] {
        INICIO = 2'd0,
        CONTAR = 2'd1,
        PAUSAR = 2'd2,
        PARAR  = 2'd3
    } estado_t;

    typedef enum logic [1:0] {
        CMD_NENHUM,
        CMD_CONTA,
        CMD_PAUSA,
        CMD_PARA
    } comando_t;

    // Only the strongest command of a cycle survives; the others are dropped.
    function automatic comando_t prioriza(input logic conta, input logic pausa, input logic para);
        if (para)
            return CMD_PARA;
        else if (pausa)
            return CMD_PAUSA;
        else if (conta)
            return CMD_CONTA;
        else
            return CMD_NENHUM;
    endfunction

endpackage

// File: rtl/filtro_botao.sv
// One push button: 2-flop synchronizer, stable-level filter and rising-edge
// detector producing a single-cycle command pulse per accepted press.
module filtro_botao
    import cronometro_pkg::*;
#(
    parameter int CICLOS_FILTRO = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic botao,
    output logic pulso
);

    localparam int FW = $clog2(CICLOS_FILTRO + 1);
    localparam logic [FW-1:0] FILTRO_MAX = FW'(CICLOS_FILTRO - 1);

    logic          sync1_q, sync2_q;
    logic [1:0]    vld_q;
    logic          nivel_q, nivel_d;
    logic          armado_q, armado_d;
    logic [FW-1:0] cnt_q, cnt_d;
    logic          pulso_q, pulso_d;

    // NOTE: every _d signal gets a default first, so no latch can be inferred.
    always_comb begin
        nivel_d  = nivel_q;
        armado_d = armado_q;
        cnt_d    = '0;
        pulso_d  = 1'b0;
        // Until armed the counter measures a stable release; afterwards it
        // measures a stable change away from the accepted level.
        if (vld_q[1] && (sync2_q == (armado_q ? ~nivel_q : 1'b0))) begin
            if (cnt_q == FILTRO_MAX) begin
                if (armado_q) begin
                    nivel_d = ~nivel_q;
                    pulso_d = ~nivel_q;
                end
                armado_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            vld_q    <= 2'b00;
            nivel_q  <= 1'b0;
            armado_q <= 1'b0;
            cnt_q    <= '0;
            pulso_q  <= 1'b0;
        end else begin
            sync1_q  <= botao;
            sync2_q  <= sync1_q;
            vld_q    <= {vld_q[0], 1'b1};
            nivel_q  <= nivel_d;
            armado_q <= armado_d;
            cnt_q    <= cnt_d;
            pulso_q  <= pulso_d;
        end
    end

    assign pulso = pulso_q;

endmodule

// File: rtl/controle_cronometro.sv
// Stopwatch control: debounced start/pause/stop commands drive a four-state
// FSM and a tenth-of-second prescaler that emits tick_decimo pulses.
module controle_cronometro
    import cronometro_pkg::*;
#(
    parameter int CICLOS_DECIMO = 5000000,
    parameter int CICLOS_FILTRO = 500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       conta,
    input  logic       pausa,
    input  logic       para,
    output logic [1:0] estado,
    output logic       contando,
    output logic       tick_decimo,
    output logic       limpar,
    output logic       enable
);

    localparam int PW = $clog2(CICLOS_DECIMO);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CICLOS_DECIMO - 1);

    logic cmd_conta, cmd_pausa, cmd_para;

    filtro_botao #(.CICLOS_FILTRO(CICLOS_FILTRO)) u_conta (
        .clk(clk), .reset(reset), .botao(conta), .pulso(cmd_conta)
    );
    filtro_botao #(.CICLOS_FILTRO(CICLOS_FILTRO)) u_pausa (
        .clk(clk), .reset(reset), .botao(pausa), .pulso(cmd_pausa)
    );
    filtro_botao #(.CICLOS_FILTRO(CICLOS_FILTRO)) u_para (
        .clk(clk), .reset(reset), .botao(para), .pulso(cmd_para)
    );

    comando_t      cmd;
    estado_t       estado_q, estado_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          contando_q, contando_d;
    logic          tick_q, tick_d;
    logic          limpar_q, limpar_d;
    logic          enable_q, enable_d;

    always_comb begin
        cmd      = prioriza(cmd_conta, cmd_pausa, cmd_para);
        estado_d = estado_q;
        case (estado_q)
            INICIO: if (cmd == CMD_CONTA) estado_d = CONTAR;
            CONTAR: if (cmd == CMD_PAUSA) estado_d = PAUSAR;
                    else if (cmd == CMD_PARA) estado_d = PARAR;
            PAUSAR: if (cmd == CMD_CONTA) estado_d = CONTAR;
                    else if (cmd == CMD_PARA) estado_d = PARAR;
            PARAR:  if (cmd == CMD_CONTA) estado_d = INICIO;
        endcase

        // The cycle that leaves CONTAR for PAUSAR still counts, so a resume
        // continues the partial tenth where it stopped.
        if (estado_d == INICIO || estado_d == PARAR)
            presc_d = '0;
        else if (estado_q == CONTAR)
            presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
        else
            presc_d = presc_q;

        contando_d = (estado_d == CONTAR);
        enable_d   = (estado_d != INICIO);
        tick_d     = (estado_q == CONTAR) && (estado_d == CONTAR) && (presc_q == PRESC_MAX);
        limpar_d   = (estado_q == PARAR) && (estado_d == INICIO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q   <= INICIO;
            presc_q    <= '0;
            contando_q <= 1'b0;
            tick_q     <= 1'b0;
            limpar_q   <= 1'b0;
            enable_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            presc_q    <= presc_d;
            contando_q <= contando_d;
            tick_q     <= tick_d;
            limpar_q   <= limpar_d;
            enable_q   <= enable_d;
        end
    end

    assign estado      = estado_q;
    assign contando    = contando_q;
    assign tick_decimo = tick_q;
    assign limpar      = limpar_q;
    assign enable      = enable_q;

endmodule

// File: tb/tb_controle_cronometro.sv
// Self-checking bench for controle_cronometro: directed scenarios followed by
// random button activity, all compared cycle by cycle against a reference model.
module tb_controle_cronometro;

    localparam int N = 5;
    localparam int F = 4;

    logic       clk = 1'b0;
    logic       reset, conta, pausa, para;
    logic [1:0] estado;
    logic       contando, tick_decimo, limpar, enable;

    controle_cronometro #(.CICLOS_DECIMO(N), .CICLOS_FILTRO(F)) dut (
        .clk(clk), .reset(reset), .conta(conta), .pausa(pausa), .para(para),
        .estado(estado), .contando(contando), .tick_decimo(tick_decimo),
        .limpar(limpar), .enable(enable)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Next state indexed by [state][command]; command 0 none, 1 conta, 2 pausa, 3 para.
    int trans [4][4] = '{'{0, 1, 0, 0}, '{1, 1, 2, 3}, '{2, 1, 2, 3}, '{3, 0, 3, 3}};

    int q_raw [3][$];
    bit armed [3];
    bit level [3];
    bit cmd   [3];
    int run   [3];
    int m_state, m_phase;
    bit m_tick, m_limpar;

    int n_tick, n_limpar, n_start, prev_estado;
    bit seen [4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 3; b++) begin
            q_raw[b].delete();
            armed[b] = 1'b0;
            level[b] = 1'b0;
            cmd[b]   = 1'b0;
            run[b]   = 0;
        end
        m_state  = 0;
        m_phase  = 0;
        m_tick   = 1'b0;
        m_limpar = 1'b0;
    endtask

    // One rising edge of the reference: command from the previous cycle moves
    // the state, then each button's delayed sample updates its filter.
    task automatic model_edge();
        int raw [3];
        int sel, nxt, tgt, v;
        raw[0] = int'(conta);
        raw[1] = int'(pausa);
        raw[2] = int'(para);
        sel = cmd[2] ? 3 : cmd[1] ? 2 : cmd[0] ? 1 : 0;
        nxt = trans[m_state][sel];
        m_tick   = (m_state == 1) && (nxt == 1) && (m_phase == N - 1);
        m_limpar = (m_state == 3) && (nxt == 0);
        if (nxt == 0 || nxt == 3)
            m_phase = 0;
        else if (m_state == 1)
            m_phase = (m_phase + 1) % N;
        m_state = nxt;
        for (int b = 0; b < 3; b++) begin
            cmd[b] = 1'b0;
            q_raw[b].push_back(raw[b]);
            if (q_raw[b].size() > 2) begin
                v   = q_raw[b].pop_front();
                tgt = armed[b] ? int'(!level[b]) : 0;
                if (v == tgt) run[b]++;
                else run[b] = 0;
                if (run[b] == F) begin
                    run[b] = 0;
                    if (armed[b]) begin
                        level[b] = !level[b];
                        cmd[b]   = level[b];
                    end
                    armed[b] = 1'b1;
                end
            end
        end
    endtask

    // Inputs are set at the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check("estado", 32'(estado), 32'(m_state));
        check("contando", 32'(contando), 32'(m_state == 1));
        check("enable", 32'(enable), 32'(m_state != 0));
        check("tick_decimo", 32'(tick_decimo), 32'(m_tick));
        check("limpar", 32'(limpar), 32'(m_limpar));
        if (tick_decimo) n_tick++;
        if (limpar) n_limpar++;
        if (estado == 2'd1 && prev_estado == 0) n_start++;
        prev_estado = int'(estado);
        seen[estado] = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_estado(input logic [1:0] target, input int budget, input string tag);
        for (int i = 0; i < budget; i++) begin
            if (estado == target) break;
            cycle();
        end
        check(tag, 32'(estado), 32'(target));
    endtask

    task automatic cycles_to_tick(input int budget, output int n);
        n = budget + 1;
        for (int i = 1; i <= budget; i++) begin
            cycle();
            if (tick_decimo) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int hold [3];
        logic lvl [3];

        reset = 1'b1; conta = 1'b0; pausa = 1'b0; para = 1'b0;
        prev_estado = 0;
        model_reset();
        @(negedge clk);
        repeat (2) cycle();
        check("rst_estado", 32'(estado), 32'd0);
        check("rst_enable", 32'(enable), 32'd0);
        reset = 1'b0;
        repeat (10) cycle();

        // Short glitch on conta must not be accepted.
        conta = 1'b1; repeat (3) cycle();
        conta = 1'b0; repeat (12) cycle();
        check("glitch_estado", 32'(estado), 32'd0);

        // Clean press: one start, then a tick every N cycles.
        n_start = 0;
        conta = 1'b1; repeat (10) cycle();
        conta = 1'b0;
        wait_estado(2'd1, 10, "start_estado");
        check("start_once", 32'(n_start), 32'd1);
        check("start_enable", 32'(enable), 32'd1);
        check("start_contando", 32'(contando), 32'd1);
        cycles_to_tick(20, n);
        cycles_to_tick(20, n);
        check("tick_period", 32'(n), 32'(N));

        // Pause lands with the prescaler at 2; resume completes the partial tenth.
        cycle();
        pausa = 1'b1; repeat (8) cycle();
        pausa = 1'b0;
        wait_estado(2'd2, 10, "pause_estado");
        n_tick = 0;
        repeat (15) cycle();
        check("pause_no_tick", 32'(n_tick), 32'd0);
        conta = 1'b1;
        wait_estado(2'd1, 12, "resume_estado");
        cycles_to_tick(20, n);
        check("resume_first_tick", 32'(n), 32'd2);
        conta = 1'b0; repeat (8) cycle();

        // All three together: stop wins, PAUSAR never visited.
        for (int s = 0; s < 4; s++) seen[s] = 1'b0;
        conta = 1'b1; pausa = 1'b1; para = 1'b1;
        wait_estado(2'd3, 12, "prio_estado");
        check("prio_no_pausar", 32'(seen[2]), 32'd0);
        conta = 1'b0; pausa = 1'b0; para = 1'b0;
        repeat (8) cycle();

        // Leaving PARAR clears once and restarts with a full first tenth.
        n_limpar = 0;
        conta = 1'b1;
        wait_estado(2'd0, 12, "clear_estado");
        conta = 1'b0; repeat (8) cycle();
        check("clear_once", 32'(n_limpar), 32'd1);
        check("clear_enable", 32'(enable), 32'd0);
        conta = 1'b1;
        wait_estado(2'd1, 12, "restart_estado");
        cycles_to_tick(20, n);
        check("restart_first_tick", 32'(n), 32'(N));
        conta = 1'b0; repeat (8) cycle();

        // Asynchronous reset in PAUSAR with buttons held; they stay ignored until re-pressed.
        pausa = 1'b1;
        wait_estado(2'd2, 12, "pre_reset_estado");
        #2;
        reset = 1'b1; conta = 1'b1;
        #1;
        check("async_estado", 32'(estado), 32'd0);
        check("async_contando", 32'(contando), 32'd0);
        check("async_enable", 32'(enable), 32'd0);
        check("async_tick", 32'(tick_decimo), 32'd0);
        check("async_limpar", 32'(limpar), 32'd0);
        model_reset();
        cycle();
        reset = 1'b0;
        repeat (20) cycle();
        check("held_ignored", 32'(estado), 32'd0);
        conta = 1'b0; pausa = 1'b0; repeat (10) cycle();
        conta = 1'b1; repeat (10) cycle();
        conta = 1'b0;
        check("repress_estado", 32'(estado), 32'd1);
        repeat (8) cycle();

        // Random button activity with occasional resets.
        for (int b = 0; b < 3; b++) begin
            hold[b] = 0;
            lvl[b]  = 1'b0;
        end
        for (int k = 0; k < 1500; k++) begin
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    lvl[b]  = ($urandom_range(0, 2) == 0);
                    hold[b] = $urandom_range(1, 12);
                end
                hold[b]--;
            end
            conta = lvl[0]; pausa = lvl[1]; para = lvl[2];
            reset = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_cronometro.md
CONTROLE_CRONOMETRO -- requirements
Module: controle_cronometro

Interface
REQ-001 Parameter CICLOS_DECIMO, default 5000000, clk cycles per 0.1 s tick (50 MHz clock); legal range >= 2.
REQ-002 Parameter CICLOS_FILTRO, default 500000, consecutive stable cycles needed to accept a button level (10 ms); legal range >= 1.
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 conta  input  1  raw start/resume button, active-high, asynchronous to clk.
REQ-006 pausa  input  1  raw pause button, active-high, asynchronous to clk.
REQ-007 para  input  1  raw stop button, active-high, asynchronous to clk.
REQ-008 estado  output  2  current state: INICIO=0, CONTAR=1, PAUSAR=2, PARAR=3.
REQ-009 contando  output  1  high while estado==CONTAR.
REQ-010 tick_decimo  output  1  one-cycle pulse; the counter advances one tenth per pulse.
REQ-011 limpar  output  1  one-cycle pulse; the counter clears tenths and seconds to 0.
REQ-012 enable  output  1  display enable; low only in INICIO.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a filter whose accepted level changes only after CICLOS_FILTRO consecutive cycles of the new synchronized value.
REQ-014 A command pulse SHALL be produced for one cycle on each 0->1 transition of an accepted level; holding a button SHALL yield exactly one command.
REQ-015 When commands coincide in one cycle, priority SHALL be para > pausa > conta; lower-priority commands in that cycle are discarded.
REQ-016 INICIO: conta -> CONTAR; pausa, para ignored.
REQ-017 CONTAR: pausa -> PAUSAR; para -> PARAR; conta ignored.
REQ-018 PAUSAR: conta -> CONTAR; para -> PARAR; pausa ignored.
REQ-019 PARAR: conta -> INICIO with limpar high for exactly the cycle estado becomes INICIO; pausa, para ignored.
REQ-020 The state register SHALL update on the clock edge following the command pulse; estado, contando, enable SHALL be registered and consistent in the same cycle.
REQ-021 A prescaler SHALL count 0..CICLOS_DECIMO-1 only while in CONTAR, wrapping to 0; tick_decimo SHALL be high in the cycle after the prescaler holds CICLOS_DECIMO-1 in CONTAR.
REQ-022 The prescaler SHALL hold its value in PAUSAR (resume keeps the partial tenth), and SHALL be 0 in INICIO and PARAR.
REQ-023 No tick_decimo SHALL occur in any cycle where estado != CONTAR, including the cycle a pausa/para transition takes effect.
REQ-024 The prescaler SHALL be ceil(log2(CICLOS_DECIMO)) bits wide; the filter counter ceil(log2(CICLOS_FILTRO+1)) bits wide.

Reset
REQ-025 While reset is high: estado=INICIO, contando=0, tick_decimo=0, limpar=0, enable=0, prescaler=0, synchronizers, accepted levels and filter counters=0.
REQ-026 Reset asserted mid-operation (any state, any prescaler value) SHALL take effect immediately, without waiting for clk; no command pulse SHALL be generated by a button already held when reset releases until it is released and pressed again.

Structure
REQ-027 State encodings (INICIO, CONTAR, PAUSAR, PARAR) SHALL live in shared package cronometro_pkg, also used by the counter and display blocks.
REQ-028 Synchronizer, filter and edge detector SHALL be one sub-module, filtro_botao, instantiated three times.

Verification (CICLOS_DECIMO=5, CICLOS_FILTRO=4)
REQ-029 Reset, press conta 10 cycles -> estado 0->1 exactly once, enable=1, contando=1; tick_decimo every 5th cycle thereafter.
REQ-030 conta held 3 cycles (glitch) -> no transition; estado stays 0.
REQ-031 In CONTAR with prescaler=2, press pausa -> estado=2, no ticks; press conta -> first tick 2 cycles after resume (prescaler continues from 2).
REQ-032 conta, pausa, para asserted together in CONTAR -> estado=3; no PAUSAR visited.
REQ-033 In PARAR press conta -> estado=0, limpar pulses once, enable=0, prescaler=0; next conta restarts with full 5-cycle first tick.
REQ-034 Assert reset for 1 cycle in PAUSAR while pausa held -> all outputs at reset values; no command until pausa is released and re-pressed.
